// File: rtl/isa_pkg.sv
// ============================================================================
// Module      : isa_pkg
// Description : Opcode constants and shared types for fetch and decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    localparam logic [5:0]  RTYPE = 6'b101010;
    localparam logic [5:0]  VLD   = 6'b100000;
    localparam logic [5:0]  VSD   = 6'b100001;
    localparam logic [5:0]  VBEZ  = 6'b100010;
    localparam logic [5:0]  VBNEZ = 6'b100011;
    localparam logic [5:0]  VNOP  = 6'b111100;

    localparam logic [0:31] NOP_INST         = {VNOP, 26'b0};
    localparam logic [0:31] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [0:31] inst;
        logic [0:31] pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// Module      : fetch_skid_buf
// Description : One-entry skid buffer catching the fetch in flight on a stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buf
    import isa_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_consume,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_entry,
    output logic         o_valid
);

    fetch_entry_t r_entry;
    logic         r_valid;

    // Flush outranks load so a redirect during a stall discards the entry.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_entry <= i_entry;
            r_valid <= 1'b1;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_entry = r_entry;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module      : inst_fetch
// Description : PC, fetch issue to a 1-cycle memory, skid buffer and IF/ID reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch
    import isa_pkg::*;
#(
    parameter logic [0:31] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [0:31] branch_target,
    output logic [0:31] imem_addr,
    output logic        imem_en,
    input  logic [0:31] imem_data,
    output logic [0:31] ID_inst,
    output logic [0:31] ID_pc,
    output logic        ID_valid
);

    localparam logic [0:31] c_pc_step = 32'(PC_STEP);

    logic [0:31]  r_pc;
    logic [0:31]  r_f_pc;
    logic         r_f_valid;

    fetch_entry_t w_skid_in;
    fetch_entry_t w_skid_out;
    logic         w_skid_valid;
    logic         w_skid_load;
    logic         w_skid_consume;

    assign imem_addr = r_pc;
    assign imem_en   = !stall && !branch_taken && !reset;

    assign w_skid_in      = '{inst: imem_data, pc: r_f_pc};
    assign w_skid_load    = stall && !branch_taken && r_f_valid;
    assign w_skid_consume = !stall && !branch_taken && w_skid_valid;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst       (reset),
        .i_load    (w_skid_load),
        .i_consume (w_skid_consume),
        .i_flush   (branch_taken),
        .i_entry   (w_skid_in),
        .o_entry   (w_skid_out),
        .o_valid   (w_skid_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_f_valid <= 1'b0;
            ID_valid  <= 1'b0;
            ID_inst   <= NOP_INST;
            ID_pc     <= '0;
        end else if (branch_taken) begin
            r_pc      <= branch_target;
            r_f_valid <= 1'b0;
            ID_valid  <= 1'b0;
            ID_inst   <= NOP_INST;
        end else if (stall) begin
            // ID and PC hold; the word on imem_data moves into the skid.
            r_f_valid <= 1'b0;
        end else begin
            if (w_skid_valid) begin
                ID_valid <= 1'b1;
                ID_inst  <= w_skid_out.inst;
                ID_pc    <= w_skid_out.pc;
            end else if (r_f_valid) begin
                ID_valid <= 1'b1;
                ID_inst  <= imem_data;
                ID_pc    <= r_f_pc;
            end else begin
                ID_valid <= 1'b0;
                ID_inst  <= NOP_INST;
            end
            r_f_pc    <= r_pc;
            r_f_valid <= 1'b1;
            r_pc      <= r_pc + c_pc_step;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module      : tb_inst_fetch
// Description : Directed bench for inst_fetch with a word=address memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [0:31] branch_target = '0;

    logic [0:31] imem_addr, imem_data, ID_inst, ID_pc;
    logic        imem_en, ID_valid;
    logic [0:31] imem_addr2, imem_data2, ID_inst2, ID_pc2;
    logic        imem_en2, ID_valid2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .ID_inst(ID_inst), .ID_pc(ID_pc), .ID_valid(ID_valid)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr2), .imem_en(imem_en2),
        .imem_data(imem_data2), .ID_inst(ID_inst2), .ID_pc(ID_pc2), .ID_valid(ID_valid2)
    );

    // Synchronous memory returning word = address, one-cycle latency.
    initial imem_data  = '0;
    initial imem_data2 = '0;
    always @(posedge clk) if (imem_en)  imem_data  <= imem_addr;
    always @(posedge clk) if (imem_en2) imem_data2 <= imem_addr2;

    // A full skid with a fetch still in flight must never occur.
    always @(negedge clk) begin
        if (!reset && dut.w_skid_valid && dut.r_f_valid) begin
            errors++;
            $display("FAIL skid_overflow: skid full while fetch in flight at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc, imem_en, imem_addr} !== {1'b0, NOP_INST, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b inst=%h pc=%h en=%b addr=%h want v=0 inst=%h pc=0 en=0 addr=0",
                     ID_valid, ID_inst, ID_pc, imem_en, imem_addr, NOP_INST);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_en, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_fetch: got en=%b addr=%h want en=1 addr=0", imem_en, imem_addr);
        end
        step();
        checks++;
        if (ID_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency: ID_valid=%b one edge after release, want 0", ID_valid);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL first_inst: got v=%b inst=%h pc=%h want v=1 inst=0 pc=0", ID_valid, ID_inst, ID_pc);
        end
    endtask

    task automatic test_free_run();
        logic [0:31] exp;
        for (int i = 1; i <= 3; i++) begin
            exp = 32'(4 * i);
            step();
            checks++;
            if ({ID_valid, ID_inst, ID_pc} !== {1'b1, exp, exp}) begin
                errors++;
                $display("FAIL free_run[%0d]: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                         i, ID_valid, ID_inst, ID_pc, exp, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [0:31] exp;
        checks++;
        if (imem_data !== 32'h10) begin
            errors++;
            $display("FAIL stall_setup: imem_data=%h want 00000010", imem_data);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (imem_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_en[%0d]: imem_en=%b want 0", i, imem_en);
            end
            step();
            checks++;
            if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h0C, 32'h0C}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h want v=1 inst=0000000c pc=0000000c",
                         i, ID_valid, ID_inst, ID_pc);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = 32'h10 + 32'(4 * i);
            step();
            checks++;
            if ({ID_valid, ID_inst, ID_pc} !== {1'b1, exp, exp}) begin
                errors++;
                $display("FAIL stall_release[%0d]: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                         i, ID_valid, ID_inst, ID_pc, exp, exp);
            end
        end
    endtask

    task automatic test_branch();
        checks++;
        if ({imem_data, imem_addr} !== {32'h20, 32'h24}) begin
            errors++;
            $display("FAIL branch_setup: data=%h addr=%h want 00000020 00000024", imem_data, imem_addr);
        end
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        #1;
        checks++;
        if ({ID_valid, ID_inst, ID_pc, imem_en, imem_addr} !== {1'b0, NOP_INST, 32'h1C, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL branch_bubble0: got v=%b inst=%h pc=%h en=%b addr=%h want v=0 inst=%h pc=0000001c en=1 addr=00000100",
                     ID_valid, ID_inst, ID_pc, imem_en, imem_addr, NOP_INST);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b0, NOP_INST, 32'h1C}) begin
            errors++;
            $display("FAIL branch_bubble1: got v=%b inst=%h pc=%h want v=0 inst=%h pc=0000001c",
                     ID_valid, ID_inst, ID_pc, NOP_INST);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h100, 32'h100}) begin
            errors++;
            $display("FAIL branch_target: got v=%b inst=%h pc=%h want v=1 inst=00000100 pc=00000100",
                     ID_valid, ID_inst, ID_pc);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h104, 32'h104}) begin
            errors++;
            $display("FAIL branch_next: got v=%b inst=%h pc=%h want v=1 inst=00000104 pc=00000104",
                     ID_valid, ID_inst, ID_pc);
        end
    endtask

    task automatic test_branch_during_stall();
        stall = 1'b1;
        step();
        checks++;
        if ({ID_valid, ID_inst} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL bstall_hold: got v=%b inst=%h want v=1 inst=00000104", ID_valid, ID_inst);
        end
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        stall        = 1'b0;
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b0, NOP_INST, 32'h104}) begin
            errors++;
            $display("FAIL bstall_bubble0: got v=%b inst=%h pc=%h want v=0 inst=%h pc=00000104",
                     ID_valid, ID_inst, ID_pc, NOP_INST);
        end
        step();
        checks++;
        if (ID_valid !== 1'b0) begin
            errors++;
            $display("FAIL bstall_bubble1: ID_valid=%b inst=%h want 0", ID_valid, ID_inst);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h100, 32'h100}) begin
            errors++;
            $display("FAIL bstall_target: got v=%b inst=%h pc=%h want v=1 inst=00000100 pc=00000100",
                     ID_valid, ID_inst, ID_pc);
        end
    endtask

    task automatic test_reset_midstream();
        stall = 1'b1;
        step();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({ID_valid, ID_inst, ID_pc, imem_en} !== {1'b0, NOP_INST, 32'h0, 1'b0}) begin
                errors++;
                $display("FAIL midreset[%0d]: got v=%b inst=%h pc=%h en=%b want v=0 inst=%h pc=0 en=0",
                         i, ID_valid, ID_inst, ID_pc, imem_en, NOP_INST);
            end
        end
        reset = 1'b0;
        stall = 1'b0;
        #1;
        checks++;
        if ({imem_en, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL midreset_restart: got en=%b addr=%h want en=1 addr=0", imem_en, imem_addr);
        end
        step();
        checks++;
        if (ID_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: ID_valid=%b inst=%h want 0", ID_valid, ID_inst);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL midreset_first: got v=%b inst=%h pc=%h want v=1 inst=0 pc=0", ID_valid, ID_inst, ID_pc);
        end
        step();
        checks++;
        if ({ID_valid, ID_inst, ID_pc} !== {1'b1, 32'h4, 32'h4}) begin
            errors++;
            $display("FAIL midreset_second: got v=%b inst=%h pc=%h want v=1 inst=4 pc=4", ID_valid, ID_inst, ID_pc);
        end
    endtask

    task automatic test_wrap();
        logic [0:31] exp_addr [0:5];
        logic [0:31] exp_inst [0:3];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
        exp_inst = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({imem_en2, imem_addr2} !== {1'b1, exp_addr[i]}) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: got en=%b addr=%h want en=1 addr=%h", i, imem_en2, imem_addr2, exp_addr[i]);
            end
            if (i >= 2) begin
                checks++;
                if ({ID_valid2, ID_inst2, ID_pc2} !== {1'b1, exp_inst[i-2], exp_inst[i-2]}) begin
                    errors++;
                    $display("FAIL wrap_id[%0d]: got v=%b inst=%h pc=%h want v=1 inst=%h pc=%h",
                             i, ID_valid2, ID_inst2, ID_pc2, exp_inst[i-2], exp_inst[i-2]);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_branch_during_stall();
        test_reset_midstream();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage with the IF/ID pipeline register, directly upstream of the decode stage. It holds the program counter and issues addresses to a synchronous instruction memory with one-cycle read latency. It presents one 32-bit instruction per cycle, with its PC and a valid flag, to decode, and inserts VNOP bubbles when no instruction is available. It absorbs decode-side stalls with a one-entry skid buffer and flushes on a taken-branch redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `PC_STEP`, default 4: byte increment per sequential fetch.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold the IF/ID register and stop issuing new fetches.
- `branch_taken`  in  1  redirect fetch to `branch_target` and flush the wrong path; has priority over `stall`.
- `branch_target`  in  [0:31]  redirect byte address.
- `imem_addr`  out  [0:31]  fetch byte address, equal to `pc_q`.
- `imem_en`  out  1  read enable: `!stall && !branch_taken && !reset`.
- `imem_data`  in  [0:31]  read data, valid the cycle after an enabled address.
- `ID_inst`  out  [0:31]  registered instruction to decode; MSB is bit 0.
- `ID_pc`  out  [0:31]  registered PC of `ID_inst`.
- `ID_valid`  out  1  `ID_inst` is a real fetched instruction.

## Operation
- State registers: `pc_q`, `f_pc_q`, `f_valid_q`, `skid_inst_q`, `skid_pc_q`, `skid_valid_q`, and the ID registers.
  - `f_valid_q`/`f_pc_q` describe the instruction currently on `imem_data`.
- Reset, highest priority:
  - `pc_q` = RESET_PC.
  - `f_valid_q` = 0 and `skid_valid_q` = 0.
  - `ID_valid` = 0, `ID_inst` = NOP_INST ({6'b111100, 26'b0}), `ID_pc` = 0.
- Redirect (`branch_taken`=1, any `stall`):
  - `pc_q` <= `branch_target`.
  - `f_valid_q` <= 0 and `skid_valid_q` <= 0.
  - `ID_valid` <= 0, `ID_inst` <= NOP_INST, `ID_pc` held.
- Stall (`stall`=1, no redirect):
  - ID registers and `pc_q` are held.
  - If `f_valid_q`: skid <= {`imem_data`, `f_pc_q`}, `skid_valid_q` <= 1, `f_valid_q` <= 0.
  - Skid already full with `f_valid_q`=1 cannot occur; the bench asserts it never happens.
- Run (`stall`=0, no redirect), ID source in priority order:
  - skid, if `skid_valid_q`; then clear `skid_valid_q`.
  - else `imem_data`/`f_pc_q`, if `f_valid_q`.
  - else a bubble: `ID_valid` <= 0, `ID_inst` <= NOP_INST, `ID_pc` held.
- Fetch issue (whenever `imem_en`=1):
  - `f_pc_q` <= `pc_q`, `f_valid_q` <= 1.
  - `pc_q` <= `pc_q` + PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Fetch not issued and no redirect: `f_valid_q` <= 0.
- No decoding is done here; opcode bits pass through untouched.

## Timing
- Sequential latency: address issued in cycle n, data on `imem_data` in n+1, visible on `ID_inst` in n+2. Throughput is 1 instruction/cycle.
- Redirect sampled at edge E:
  - target address on `imem_addr` in cycle E+1.
  - target instruction valid on `ID_*` after edge E+2.
  - exactly 2 bubble cycles on `ID_valid`.
- Stall of k cycles:
  - `ID_*` is frozen for k cycles.
  - First cycle after release: ID takes the skid entry, and the fetch of `pc_q` issues in that same cycle.
  - No instruction is lost or duplicated; zero extra bubbles after release.
- `stall` and `branch_taken` together: the redirect wins and the skid is discarded.
- Reset asserted mid-stream: all in-flight and skid contents are dropped. First fetch (RESET_PC) is issued in the cycle after reset deasserts; its instruction is valid on `ID_*` two edges later.

## Structure
- Shared package `isa_pkg` holds:
  - opcode constants RTYPE=6'b101010, VLD=6'b100000, VSD=6'b100001, VBEZ=6'b100010, VBNEZ=6'b100011, VNOP=6'b111100.
  - NOP_INST.
  - default RESET_PC.
  - Decode and this block share them.
- Sub-module `fetch_skid_buf`: one-entry buffer holding {inst, pc, valid}, with load/consume/flush controls. PC logic and ID registers live in the top.

## Test plan
- Reset, then free-run with memory returning word = address: `ID_inst` sequence 0,4,8,C… with `ID_pc` equal to it; first valid 2 edges after reset release, with no gaps.
- `stall` high 3 cycles while PC=0x10 is on `imem_data`:
  - ID holds previous 0x0C for 3 cycles.
  - after release: 0x10, 0x14, 0x18 consecutively, no repeat or skip.
- `branch_taken` with target 0x100 while 0x20 and 0x24 are in flight: `ID_valid`=0 with `ID_inst`=NOP_INST for 2 cycles, then 0x100, 0x104.
- `branch_taken` and `stall` in the same cycle with the skid full: skid is discarded, and the next valid ID is 0x100 after 2 bubbles.
- `RESET_PC`=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, 0, 4 (wrap-around).
- Reset asserted during a stall with the skid full: `ID_valid`=0, `ID_inst`=NOP_INST, `imem_en`=0 while reset is high, then restart from RESET_PC.
